// File: rtl/md_sched.sv
// md_sched: EX-stage multiply/divide scheduler owning HI/LO.
// Optional MD_FLUSH_EN adds a flush port that cancels an in-flight op.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        rd_sel,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] md_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;
    logic               flush_act;

    logic               issue;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    logic               op_mult;
    logic               op_multu;
    logic               op_div;
    logic               op_divu;
    logic               op_mthi;
    logic               op_mtlo;
    logic               is_mul;
    logic               is_div;
    logic               sgn;

    logic [63:0]        ext_a;
    logic [63:0]        ext_b;
    logic [63:0]        prod;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dvsr;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_wr;

`ifdef MD_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign op_mult  = (md_op == 3'b000);
    assign op_multu = (md_op == 3'b001);
    assign op_div   = (md_op == 3'b010);
    assign op_divu  = (md_op == 3'b011);
    assign op_mthi  = (md_op == 3'b100);
    assign op_mtlo  = (md_op == 3'b101);
    assign is_mul   = op_mult | op_multu;
    assign is_div   = op_div | op_divu;
    assign sgn      = op_mult | op_div;

    // Low 64 bits of the extended product are correct for both signednesses.
    assign ext_a = {{32{sgn & md_a[31]}}, md_a};
    assign ext_b = {{32{sgn & md_b[31]}}, md_b};
    assign prod  = ext_a * ext_b;

    // Divide on magnitudes, then restore signs; 0x80000000 wraps naturally.
    assign a_neg = sgn & md_a[31];
    assign b_neg = sgn & md_b[31];
    assign mag_a = a_neg ? (32'd0 - md_a) : md_a;
    assign mag_b = b_neg ? (32'd0 - md_b) : md_b;
    assign dvsr  = (md_b == 32'd0) ? 32'd1 : mag_b;
    assign uq    = mag_a / dvsr;
    assign ur    = mag_a % dvsr;

    // Select the pending result for the op being issued.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        unique case (1'b1)
            is_mul: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            is_div: begin
                res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
                res_hi = a_neg ? (32'd0 - ur) : ur;
                res_wr = (md_b != 32'd0);
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter update and HI/LO write strobes.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        issue   = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !flush_act) begin
                    unique case (1'b1)
                        is_mul: begin
                            issue   = 1'b1;
                            state_n = RUN;
                            cnt_n   = CNT_W'(MULT_CYCLES);
                        end
                        is_div: begin
                            issue   = 1'b1;
                            state_n = RUN;
                            cnt_n   = CNT_W'(DIV_CYCLES);
                        end
                        op_mthi: wr_hi = 1'b1;
                        op_mtlo: wr_lo = 1'b1;
                        default: begin
                            issue = 1'b0;
                        end
                    endcase
                end
            end
            RUN: begin
                if (flush_act) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Busy-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    // Capture the result at the issue edge; it is held until commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (issue) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else begin
            if (wr_hi) hi <= md_a;
            if (wr_lo) lo <= md_a;
        end
    end

    assign busy   = (state == RUN);
    assign md_out = rd_sel ? lo : hi;

endmodule
